// File: rtl/mdu_pkg.sv
// Shared encodings for the E-stage multiply/divide unit. The control unit and
// the hazard unit import this package as well.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101,
        MDU_NONE  = 3'b111
    } mdu_sel_t;

    typedef enum logic [1:0] {
        MF_HI   = 2'b00,
        MF_LO   = 2'b01,
        MF_NONE = 2'b10
    } mf_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: signed/unsigned 64-bit product and
// quotient/remainder. Outputs are zero for any sel other than mult/div.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_zero
);

    logic        w_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_b_zero;

    assign w_sgn   = ~sel[0];
    assign w_a_neg = w_sgn & a[31];
    assign w_b_neg = w_sgn & b[31];

    // The low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_a_ext = {{32{w_a_neg}}, a};
    assign w_b_ext = {{32{w_b_neg}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed division is done on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign w_a_mag  = w_a_neg ? (~a + 32'd1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 32'd1) : b;
    assign w_b_zero = (b == '0);
    assign w_b_den  = w_b_zero ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_den;
    assign w_r_mag  = w_a_mag % w_b_den;
    assign w_q      = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        hi_res   = '0;
        lo_res   = '0;
        div_zero = 1'b0;
        if (!sel[2]) begin
            if (sel[1]) begin
                hi_res   = w_r;
                lo_res   = w_q;
                div_zero = w_b_zero;
            end else begin
                {hi_res, lo_res} = w_prod;
            end
        end
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO registers, multi-cycle busy sequencing and mf
// read mux. Results are computed at start and committed when the count expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdu_en,
    input  logic        start,
    input  logic [2:0]  sel,
    input  logic [1:0]  mf_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_out
);

    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

    mdu_state_t  r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_hi_tmp;
    logic [31:0] r_lo_tmp;

    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;
    logic        w_div_zero;
    logic        w_md_start;
    logic        w_mt;

    mdu_arith u_arith (
        .sel      (sel),
        .a        (a),
        .b        (b),
        .hi_res   (w_hi_res),
        .lo_res   (w_lo_res),
        .div_zero (w_div_zero)
    );

    assign w_md_start = mdu_en && start && !sel[2];
    assign w_mt       = mdu_en && !start && (sel == MDU_MTHI || sel == MDU_MTLO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_hi_tmp <= '0;
            r_lo_tmp <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_md_start) begin
                        r_hi_tmp <= w_hi_res;
                        r_lo_tmp <= w_lo_res;
                        r_dz     <= w_div_zero;
                        r_cnt    <= sel[1] ? LP_DIV_CNT : LP_MULT_CNT;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else if (w_mt) begin
                        if (sel == MDU_MTHI) r_hi <= a;
                        else                 r_lo <= a;
                    end
                end
                RUN: begin
                    if (r_cnt == 4'd1) begin
                        // Divide by zero runs full latency but leaves HI/LO untouched.
                        if (!r_dz) begin
                            r_hi <= r_hi_tmp;
                            r_lo <= r_lo_tmp;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mf_out = '0;
        case (mf_sel)
            MF_HI:   mf_out = r_hi;
            MF_LO:   mf_out = r_lo;
            default: mf_out = '0;
        endcase
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

    a_no_start_in_run: assert property (@(posedge clk) disable iff (!reset)
        !(r_state == RUN && mdu_en && start))
        else $warning("mdu: start while busy ignored");

    a_no_mt_in_run: assert property (@(posedge clk) disable iff (!reset)
        !(r_state == RUN && w_mt))
        else $warning("mdu: mthi/mtlo while busy ignored");

endmodule
